// File: rtl/instr_enc_pkg.sv
// ----------------------------------------------------------------------------
// instr_enc_pkg
// Shared definitions for the MIPS instruction encoder: the symbolic operation
// enum, the 6-bit primary opcodes, the R-type funct codes and the NOP word.
// The control decoder imports the same constants so both sides agree on the
// encoding. Also holds the combinational field-packing function.
// ----------------------------------------------------------------------------
package instr_enc_pkg;

    // Symbolic operations accepted on req_op; codes 13..15 are illegal.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_J    = 4'd8,
        OP_ADDI = 4'd9,
        OP_ANDI = 4'd10,
        OP_ORI  = 4'd11,
        OP_SLTI = 4'd12
    } op_e;

    // Primary opcode field, instruction bits [31:26].
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;

    // R-type funct field, instruction bits [5:0].
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // sll $0,$0,0 -- the canonical MIPS no-op.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Anything past the last defined op is illegal.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_SLTI;
    endfunction

    // Control-transfer ops that own a delay slot.
    function automatic logic needs_delay_slot(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_J);
    endfunction

    // Packs the symbolic fields into a 32-bit MIPS word. Fields the format
    // does not use are simply ignored; illegal ops return NOP_WORD, but the
    // caller never pushes those.
    function automatic logic [31:0] encode_instr(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        word = NOP_WORD;
        case (op)
            OP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_ADD};
            OP_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_SUB};
            OP_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_AND};
            OP_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_OR};
            OP_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_SLT};
            OP_LW:   word = {OPC_LW,   rs, rt, imm};
            OP_SW:   word = {OPC_SW,   rs, rt, imm};
            OP_BEQ:  word = {OPC_BEQ,  rs, rt, imm};
            OP_J:    word = {OPC_J,    target};
            OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
            OP_ANDI: word = {OPC_ANDI, rs, rt, imm};
            OP_ORI:  word = {OPC_ORI,  rs, rt, imm};
            OP_SLTI: word = {OPC_SLTI, rs, rt, imm};
            default: word = NOP_WORD;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// ----------------------------------------------------------------------------
// enc_fifo
// Synchronous FIFO buffering encoded instruction words. Can write one or two
// words per cycle (the second slot carries delay-slot padding) and pops one.
// Pointers are log2(DEPTH) bits plus a wrap bit; full/empty come from pointer
// compare. The caller only pushes when enough space is free.
//
// Ports:
//   clk_i     clock
//   clear_i   synchronous clear of both pointers (reset or flush)
//   push_i    write wdata0_i this cycle
//   push2_i   with push_i, also write wdata1_i behind wdata0_i
//   wdata0_i  first word written
//   wdata1_i  second word written when push2_i
//   pop_i     drop the head word (ignored when empty)
//   rdata_o   head word, zero while empty
//   full_o    no free entries
//   empty_o   no stored entries
//   count_o   number of stored entries
// ----------------------------------------------------------------------------
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       push2_i,
    input  logic [WIDTH-1:0]           wdata0_i,
    input  logic [WIDTH-1:0]           wdata1_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Equal pointers mean empty; same index with differing wrap bits means full.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    // Next pointer values: the write pointer advances by one or two words,
    // the read pointer by one on a pop of a non-empty FIFO.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) begin
            wptr_d = wptr_q + (push2_i ? PW'(2) : PW'(1));
        end
        if (pop_i && !empty_o) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    // Pointer registers; clear wins over any push or pop in the same cycle.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is never reset; the pointers alone decide what is valid.
    // The second word lands in the slot after the first, wrapping naturally.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata0_i;
            if (push2_i) begin
                mem_q[wptr_q[AW-1:0] + AW'(1)] <= wdata1_i;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Turns symbolic instruction requests into 32-bit MIPS words, buffers them in
// enc_fifo and streams them to an instruction-memory write port with an
// auto-incrementing byte address. Inverse of the main control decoder.
//
// Configuration macro: ENC_DELAY_SLOT_EN
//   defined   -> every accepted BEQ/J is followed by a NOP word, pushed in
//                the same cycle; requests need two free entries.
//   undefined -> no padding; requests need one free entry.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (priority over flush)
//   flush        synchronous clear of FIFO, address, counter and error flag
//   req_valid    request present
//   req_ready    request can be accepted
//   req_op       operation (instr_enc_pkg::op_e, 13..15 illegal)
//   req_rs       rs field
//   req_rt       rt field
//   req_rd       rd field (R-type)
//   req_imm      immediate / branch offset (I-type)
//   req_target   jump target (J-type)
//   out_valid    encoded word available
//   out_ready    memory accepts the word
//   out_data     encoded word
//   out_addr     byte address of out_data
//   err_illegal  sticky flag: an illegal op was accepted
//   words_out    words emitted, saturating at 0xFFFF
// ----------------------------------------------------------------------------
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [15:0]       words_out
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]     fifoCount;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [31:0]       fifoData;
    logic [31:0]       encWord;
    logic              roomOk;
    logic              pushNop;
    logic              clearAll;
    logic              accept;
    logic              opLegal;
    logic              pushWord;
    logic              popWord;

    logic [ADDR_W-1:0] outAddr_q, outAddr_d;
    logic [15:0]       wordsOut_q, wordsOut_d;
    logic              errIllegal_q, errIllegal_d;

`ifdef ENC_DELAY_SLOT_EN
    // A branch/jump plus its NOP must go in together, so every request waits
    // for two free entries even if it will only use one.
    assign roomOk  = !fifoFull && (fifoCount != CW'(FIFO_DEPTH - 1));
    assign pushNop = needs_delay_slot(req_op);
`else
    // Occupancy is only needed for the two-entry check of the padded build.
    logic unusedCount;
    assign unusedCount = ^fifoCount;
    assign roomOk      = !fifoFull;
    assign pushNop     = 1'b0;
`endif

    // Readiness depends only on registered occupancy, never on out_ready, so
    // a full FIFO refuses a push even in a cycle where it is also popped.
    assign req_ready = !rst && roomOk;
    assign clearAll  = rst || flush;
    assign accept    = req_valid && req_ready && !flush;
    assign opLegal   = is_legal_op(req_op);
    assign pushWord  = accept && opLegal;
    assign popWord   = out_valid && out_ready && !clearAll;
    assign encWord   = encode_instr(req_op, req_rs, req_rt, req_rd, req_imm, req_target);

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i    (clk),
        .clear_i  (clearAll),
        .push_i   (pushWord),
        .push2_i  (pushNop),
        .wdata0_i (encWord),
        .wdata1_i (NOP_WORD),
        .pop_i    (popWord),
        .rdata_o  (fifoData),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty),
        .count_o  (fifoCount)
    );

    assign out_valid   = !fifoEmpty;
    assign out_data    = fifoData;
    assign out_addr    = outAddr_q;
    assign err_illegal = errIllegal_q;
    assign words_out   = wordsOut_q;

    // Output-side bookkeeping: each pop moves the address one word on
    // (wrapping silently) and bumps the saturating word counter. An illegal
    // op still completes its handshake but only raises the sticky error.
    always_comb begin
        outAddr_d    = outAddr_q;
        wordsOut_d   = wordsOut_q;
        errIllegal_d = errIllegal_q;
        if (flush) begin
            outAddr_d    = START_ADDR;
            wordsOut_d   = '0;
            errIllegal_d = 1'b0;
        end else begin
            if (popWord) begin
                outAddr_d  = outAddr_q + ADDR_W'(4);
                wordsOut_d = (wordsOut_q == 16'hFFFF) ? wordsOut_q : wordsOut_q + 16'd1;
            end
            if (accept && !opLegal) begin
                errIllegal_d = 1'b1;
            end
        end
    end

    // Bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            outAddr_q    <= START_ADDR;
            wordsOut_q   <= '0;
            errIllegal_q <= 1'b0;
        end else begin
            outAddr_q    <= outAddr_d;
            wordsOut_q   <= wordsOut_d;
            errIllegal_q <= errIllegal_d;
        end
    end

endmodule
